// File: rtl/viterbi_ber_monitor.sv
// viterbi_ber_monitor
//   Bit-error-rate checker placed after an encoder -> channel -> Viterbi
//   decoder chain. Raw encoder input bits are buffered in a reference FIFO;
//   every decoded bit pops one reference bit and the two are compared. Because
//   the FIFO absorbs the decoder latency, no delay tuning is needed.
//
//   A start_i pulse flushes the FIFO, clears all counts and flags and begins a
//   measurement. The first SKIP decoded bits are discarded (SYNC, traceback
//   warm-up). The next WINDOW decoded bits are compared (RUN). The result is
//   then frozen in DONE until the next start_i.
//
//   Optional feature: define BER_BURST_EN to track the longest run of
//   consecutive mismatches in max_burst_o. Without it, max_burst_o is tied to 0.
//
// Parameters
//   DEPTH   reference FIFO depth (power of 2, >= decoder latency + 2)
//   SKIP    leading decoded bits discarded, 0 = none
//   WINDOW  compared bits per measurement (1 .. 2**CW-1)
//   CW      width of the count outputs
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active-low
//   start_i      1-cycle pulse: flush, clear, begin measurement
//   ref_valid_i  ref_bit_i valid
//   ref_bit_i    raw encoder input bit
//   dec_valid_i  dec_bit_i valid
//   dec_bit_i    decoder output bit
//   busy_o       high in SYNC or RUN
//   done_o       window complete, held until next start_i
//   bit_ct_o     compared bits in the current window
//   err_ct_o     mismatches in the current window
//   ovf_o        sticky: reference push dropped because the FIFO was full
//   unf_o        sticky: decoded bit arrived while the FIFO was empty
//   max_burst_o  longest run of consecutive errors (BER_BURST_EN only)
module viterbi_ber_monitor #(
  parameter int DEPTH  = 64,
  parameter int SKIP   = 8,
  parameter int WINDOW = 256,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          ref_valid_i,
  input  logic          ref_bit_i,
  input  logic          dec_valid_i,
  input  logic          dec_bit_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [CW-1:0] bit_ct_o,
  output logic [CW-1:0] err_ct_o,
  output logic          ovf_o,
  output logic          unf_o,
  output logic [CW-1:0] max_burst_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int SKW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SKW-1:0] skip_ct_q, skip_ct_d;
  logic [CW-1:0] bit_ct_q, bit_ct_d;
  logic [CW-1:0] err_ct_q, err_ct_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
`ifdef BER_BURST_EN
  logic [CW-1:0] cur_burst_q, cur_burst_d;
  logic [CW-1:0] max_burst_q, max_burst_d;
  logic [CW-1:0] burst_inc;
`endif

  // Reference storage holds data only, so it carries no reset.
  logic          mem_q [DEPTH];
  logic          push;
  logic [AW-1:0] wr_addr;

  logic [PW-1:0] occ;
  logic          empty;
  logic          full;
  logic          active;
  logic          pop;
  logic          rd_bit;
  logic          mism;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    skip_ct_d = skip_ct_q;
    bit_ct_d  = bit_ct_q;
    err_ct_d  = err_ct_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
`ifdef BER_BURST_EN
    cur_burst_d = cur_burst_q;
    max_burst_d = max_burst_q;
    burst_inc   = sat_inc(cur_burst_q);
`endif
    push    = 1'b0;
    pop     = 1'b0;
    wr_addr = wr_ptr_q[AW-1:0];
    occ     = wr_ptr_q - rd_ptr_q;
    empty   = (occ == '0);
    full    = (occ == PW'(DEPTH));
    active  = (state_q == S_SYNC) || (state_q == S_RUN);
    rd_bit  = mem_q[rd_ptr_q[AW-1:0]];
    mism    = rd_bit ^ dec_bit_i;

    if (start_i) begin
      // Flush; a reference bit offered in the same cycle lands in slot 0.
      push      = ref_valid_i;
      wr_addr   = '0;
      wr_ptr_d  = ref_valid_i ? PW'(1) : '0;
      rd_ptr_d  = '0;
      skip_ct_d = '0;
      bit_ct_d  = '0;
      err_ct_d  = '0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      state_d   = (SKIP == 0) ? S_RUN : S_SYNC;
`ifdef BER_BURST_EN
      cur_burst_d = '0;
      max_burst_d = '0;
`endif
    end else if (active) begin
      pop = dec_valid_i && !empty;
      if (dec_valid_i && empty) unf_d = 1'b1;

      // Simultaneous pop frees a slot, so a push into a full FIFO is legal then.
      if (ref_valid_i) begin
        if (!full || pop) begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (state_q == S_SYNC) begin
          if (skip_ct_q == SKW'(SKIP - 1)) state_d = S_RUN;
          else skip_ct_d = skip_ct_q + SKW'(1);
        end else begin
          bit_ct_d = sat_inc(bit_ct_q);
          if (mism) err_ct_d = sat_inc(err_ct_q);
          if (bit_ct_q == CW'(WINDOW - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
`ifdef BER_BURST_EN
          if (mism) begin
            cur_burst_d = burst_inc;
            if (burst_inc > max_burst_q) max_burst_d = burst_inc;
          end else begin
            cur_burst_d = '0;
          end
`endif
        end
      end
    end

    busy_d = (state_d == S_SYNC) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      skip_ct_q <= '0;
      bit_ct_q  <= '0;
      err_ct_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
`ifdef BER_BURST_EN
      cur_burst_q <= '0;
      max_burst_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      skip_ct_q <= skip_ct_d;
      bit_ct_q  <= bit_ct_d;
      err_ct_q  <= err_ct_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
`ifdef BER_BURST_EN
      cur_burst_q <= cur_burst_d;
      max_burst_q <= max_burst_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_addr] <= ref_bit_i;
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign bit_ct_o = bit_ct_q;
  assign err_ct_o = err_ct_q;
  assign ovf_o    = ovf_q;
  assign unf_o    = unf_q;
`ifdef BER_BURST_EN
  assign max_burst_o = max_burst_q;
`else
  assign max_burst_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
module tb_viterbi_ber_monitor;

  localparam int DEPTH  = 64;
  localparam int SKIP   = 8;
  localparam int WINDOW = 256;
  localparam int CW     = 16;

  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic          ref_valid_i = 1'b0;
  logic          ref_bit_i = 1'b0;
  logic          dec_valid_i = 1'b0;
  logic          dec_bit_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] bit_ct_o;
  logic [CW-1:0] err_ct_o;
  logic          ovf_o;
  logic          unf_o;
  logic [CW-1:0] max_burst_o;

  viterbi_ber_monitor #(
    .DEPTH(DEPTH), .SKIP(SKIP), .WINDOW(WINDOW), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
    .busy_o(busy_o), .done_o(done_o), .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o),
    .ovf_o(ovf_o), .unf_o(unf_o), .max_burst_o(max_burst_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit pat [300];
  bit refq [$];
  int m_state, m_skip, m_bit, m_err, m_cur, m_max;
  bit m_done, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_burst();
`ifdef BER_BURST_EN
    return m_max;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    refq.delete();
    m_skip = 0; m_bit = 0; m_err = 0; m_cur = 0; m_max = 0;
    m_done = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".busy"}, 32'(busy_o), 32'((m_state == M_SYNC) || (m_state == M_RUN)));
    chk({tag, ".done"}, 32'(done_o), 32'(m_done));
    chk({tag, ".bit_ct"}, 32'(bit_ct_o), 32'(m_bit));
    chk({tag, ".err_ct"}, 32'(err_ct_o), 32'(m_err));
    chk({tag, ".ovf"}, 32'(ovf_o), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(unf_o), 32'(m_unf));
    chk({tag, ".max_burst"}, 32'(max_burst_o), 32'(exp_burst()));
  endtask

  // Drive one cycle, advance the reference model at the edge, compare after it.
  task automatic step(input bit st, input bit rv, input bit rb, input bit dv, input bit db);
    bit e;
    start_i = st; ref_valid_i = rv; ref_bit_i = rb; dec_valid_i = dv; dec_bit_i = db;
    @(posedge clk);
    if (st) begin
      model_clear();
      if (rv) refq.push_back(rb);
      m_state = (SKIP == 0) ? M_RUN : M_SYNC;
    end else if (m_state == M_SYNC || m_state == M_RUN) begin
      if (dv && refq.size() == 0) m_unf = 1;
      if (dv && refq.size() > 0) begin
        e = refq.pop_front();
        if (m_state == M_SYNC) begin
          m_skip++;
          if (m_skip == SKIP) m_state = M_RUN;
        end else begin
          m_bit++;
          if (e != db) begin
            m_err++;
            m_cur++;
            if (m_cur > m_max) m_max = m_cur;
          end else begin
            m_cur = 0;
          end
          if (m_bit == WINDOW) begin
            m_state = M_DONE;
            m_done = 1;
          end
        end
      end
      if (rv) begin
        if (refq.size() < DEPTH) refq.push_back(rb);
        else m_ovf = 1;
      end
    end
    #1;
    chk_all("cyc");
  endtask

  // Reference stream from offset t0; decoded copy lags by 20 cycles. With inv
  // set, RUN-compared bits 10, 11 and 100 (decoded indices 18, 19, 108) flip.
  task automatic stream(input bit inv, input int stop_bits, input int t0);
    int k;
    bit rv, rb, dv, db;
    for (int t = t0; t < 330; t++) begin
      k  = t - 20;
      rv = (t < 300);
      rb = rv ? pat[t] : 1'b0;
      dv = (k >= 0) && (k < 300);
      db = dv ? pat[k] : 1'b0;
      if (inv && dv && (k == 18 || k == 19 || k == 108)) db = ~db;
      step(1'b0, rv, rb, dv, db);
      if (stop_bits > 0 && m_bit >= stop_bits) break;
    end
  endtask

  initial begin
    logic [15:0] lfsr;
    lfsr = 16'hACE1;
    for (int i = 0; i < 300; i++) begin
      pat[i] = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
    m_state = M_IDLE;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b1;

    // Test 1: clean stream
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(1'b0, 0, 0);
    chk("t1.done", 32'(done_o), 32'd1);
    chk("t1.bit_ct", 32'(bit_ct_o), 32'd256);
    chk("t1.err_ct", 32'(err_ct_o), 32'd0);
    chk("t1.ovf_unf", 32'({ovf_o, unf_o}), 32'd0);
    chk("t1.busy", 32'(busy_o), 32'd0);

    // Test 2: three injected errors, two of them adjacent
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(1'b1, 0, 0);
    chk("t2.done", 32'(done_o), 32'd1);
    chk("t2.bit_ct", 32'(bit_ct_o), 32'd256);
    chk("t2.err_ct", 32'(err_ct_o), 32'd3);
`ifdef BER_BURST_EN
    chk("t2.max_burst", 32'(max_burst_o), 32'd2);
`else
    chk("t2.max_burst", 32'(max_burst_o), 32'd0);
`endif

    // Test 3: decoded bit with an empty FIFO
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3.unf", 32'(unf_o), 32'd1);
    chk("t3.bit_ct", 32'(bit_ct_o), 32'd0);

    // Test 4: DEPTH+1 pushes, then DEPTH in-order pops
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, pat[i], 1'b0, 1'b0);
    chk("t4.ovf", 32'(ovf_o), 32'd1);
    chk("t4.unf_pre", 32'(unf_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, pat[i]);
    chk("t4.bit_ct", 32'(bit_ct_o), 32'(DEPTH - SKIP));
    chk("t4.err_ct", 32'(err_ct_o), 32'd0);
    chk("t4.unf_mid", 32'(unf_o), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4.unf_end", 32'(unf_o), 32'd1);

    // Test 5: restart mid-RUN, with a push in the start cycle
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(1'b0, 50, 0);
    chk("t5.bit50", 32'(bit_ct_o), 32'd50);
    step(1'b1, 1'b1, pat[0], 1'b0, 1'b0);
    chk("t5.bit_ct", 32'(bit_ct_o), 32'd0);
    chk("t5.err_ct", 32'(err_ct_o), 32'd0);
    chk("t5.flags", 32'({ovf_o, unf_o, done_o}), 32'd0);
    chk("t5.busy", 32'(busy_o), 32'd1);
    stream(1'b0, 0, 1);
    chk("t5.done", 32'(done_o), 32'd1);
    chk("t5.bit_end", 32'(bit_ct_o), 32'd256);
    chk("t5.err_end", 32'(err_ct_o), 32'd0);

    // Test 6: asynchronous reset mid-RUN
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stream(1'b0, 30, 0);
    chk("t6.bit30", 32'(bit_ct_o), 32'd30);
    #2;
    rst = 1'b0;
    #1;
    m_state = M_IDLE;
    model_clear();
    chk("t6.async_bit", 32'(bit_ct_o), 32'd0);
    chk("t6.async_busy", 32'(busy_o), 32'd0);
    chk_all("t6.async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6.idle_bit", 32'(bit_ct_o), 32'd0);
    chk("t6.idle_unf", 32'(unf_o), 32'd0);
    chk("t6.idle_busy", 32'(busy_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.restart_busy", 32'(busy_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
